// File: rtl/cw_mem_responder_if.sv
// rtl/cw_mem_responder_if.sv - CW bus signal bundle between core initiator and memory responder
interface cw_mem_responder_if;
  logic        cw_req;
  logic        cw_dir;
  logic [15:0] cw_io_i;
  logic [15:0] cw_io_o;
  logic        cw_io_oe;
  logic        cw_ack;
  logic        cw_err;

  modport master (
    output cw_req, cw_dir, cw_io_i,
    input  cw_io_o, cw_io_oe, cw_ack, cw_err
  );

  modport slave (
    input  cw_req, cw_dir, cw_io_i,
    output cw_io_o, cw_io_oe, cw_ack, cw_err
  );
endinterface

// File: rtl/cw_mem_responder.sv
// rtl/cw_mem_responder.sv - CW bus memory responder over a synchronous single-port memory
// Optional start/end address window rejection is compiled in with CW_RESP_ERR_EN.
module cw_mem_responder #(
  parameter int unsigned MEM_AW     = 12,
  parameter logic [23:0] ADDR_BASE  = 24'h000000,
  parameter logic [23:0] ADDR_LIMIT = 24'hffffff
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cw_mem_responder_if.slave cw,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  output logic              mem_we,
  output logic [15:0]       mem_wdata
);

  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_HACK, S_RD_DIR, S_RD_ACK, S_RD_GAP, S_WR_DATA, S_WR_GAP, S_DONE
  } state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [2:0]  len_q;
  logic [2:0]  cnt_q;
  logic [23:0] addr_q;
  logic [15:0] rd_hold_q;
  logic        ack_q;
  logic        err_q;
  logic        we_q;

  logic range_bad;
  logic op_valid;
  logic last_word;
  logic rd_abort;

`ifdef CW_RESP_ERR_EN
  logic [23:0] start_addr;
  logic [24:0] end_addr;

  // Evaluated in ADDR, where the low address half is still on cw_io_i.
  always_comb begin
    start_addr = {addr_q[23:16], cw.cw_io_i};
    end_addr   = {1'b0, start_addr} + {22'd0, len_q};
    range_bad  = (start_addr < ADDR_BASE) || (start_addr > ADDR_LIMIT) ||
                 (end_addr > {1'b0, ADDR_LIMIT});
  end

  assign cw.cw_err = err_q;
`else
  assign range_bad = 1'b0;
  assign cw.cw_err = 1'b0;

  if (ADDR_BASE > ADDR_LIMIT) begin : g_empty_window
  end
`endif

  assign op_valid  = (op_q == OP_RD) || (op_q == OP_WR);
  assign last_word = (cnt_q == len_q);
  assign rd_abort  = !cw.cw_req || !cw.cw_dir;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_hold_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      // Strobes are set on entry to the state that presents them.
      ack_q <= 1'b0;
      err_q <= 1'b0;
      we_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cw.cw_req) begin
            op_q          <= cw.cw_io_i[5:4];
            len_q         <= cw.cw_io_i[2:0];
            addr_q[23:16] <= cw.cw_io_i[15:8];
            cnt_q         <= '0;
            state_q       <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!cw.cw_req) begin
            state_q <= S_IDLE;
          end else begin
            addr_q[15:0] <= cw.cw_io_i;
            state_q      <= S_HACK;
            if (range_bad)     err_q <= 1'b1;
            else if (op_valid) ack_q <= 1'b1;
          end
        end
        S_HACK: begin
          if (!cw.cw_req)                state_q <= S_IDLE;
          else if (err_q || !op_valid)   state_q <= S_DONE;
          else if (op_q == OP_RD)        state_q <= S_RD_DIR;
          else begin
            ack_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= S_WR_DATA;
          end
        end
        S_RD_DIR: begin
          if (!cw.cw_req) begin
            state_q <= S_IDLE;
          end else if (cw.cw_dir) begin
            ack_q   <= 1'b1;
            state_q <= S_RD_ACK;
          end
        end
        S_RD_ACK: begin
          if (rd_abort) begin
            state_q <= S_IDLE;
          end else begin
            rd_hold_q <= mem_rdata;
            addr_q    <= addr_q + 24'd1;
            cnt_q     <= cnt_q + 3'd1;
            state_q   <= last_word ? S_DONE : S_RD_GAP;
          end
        end
        S_RD_GAP: begin
          if (rd_abort) begin
            state_q <= S_IDLE;
          end else begin
            ack_q   <= 1'b1;
            state_q <= S_RD_ACK;
          end
        end
        S_WR_DATA: begin
          if (!cw.cw_req) begin
            state_q <= S_IDLE;
          end else begin
            addr_q  <= addr_q + 24'd1;
            cnt_q   <= cnt_q + 3'd1;
            state_q <= last_word ? S_DONE : S_WR_GAP;
          end
        end
        S_WR_GAP: begin
          if (!cw.cw_req) begin
            state_q <= S_IDLE;
          end else begin
            ack_q   <= 1'b1;
            we_q    <= 1'b1;
            state_q <= S_WR_DATA;
          end
        end
        S_DONE: begin
          if (!cw.cw_req && !cw.cw_dir) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read strobes are combinational so memory data lands in the RD_ACK cycle.
  assign mem_re    = cw.cw_req && cw.cw_dir && ((state_q == S_RD_DIR) || (state_q == S_RD_GAP));
  assign mem_we    = we_q;
  assign mem_wdata = (state_q == S_WR_DATA) ? cw.cw_io_i : 16'h0000;
  assign mem_addr  = addr_q[MEM_AW-1:0];

  assign cw.cw_ack   = ack_q;
  assign cw.cw_io_oe = cw.cw_dir &&
                       ((state_q == S_RD_DIR) || (state_q == S_RD_ACK) || (state_q == S_RD_GAP));
  assign cw.cw_io_o  = (state_q == S_RD_ACK) ? mem_rdata :
                       (state_q == S_IDLE)   ? 16'h0000  : rd_hold_q;

endmodule

// File: tb/tb_cw_mem_responder.sv
// tb/tb_cw_mem_responder.sv - scoreboard bench for cw_mem_responder read/write/wrap/abort/reset
module tb_cw_mem_responder;
`ifdef CW_RESP_ERR_EN
  localparam logic [23:0] TB_LIMIT = 24'h00ffff;
`else
  localparam logic [23:0] TB_LIMIT = 24'hffffff;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        mem_we;
  logic [15:0] mem_wdata;

  cw_mem_responder_if bus ();

  cw_mem_responder #(
    .MEM_AW    (12),
    .ADDR_BASE (24'h000000),
    .ADDR_LIMIT(TB_LIMIT)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .cw       (bus),
    .mem_addr (mem_addr),
    .mem_re   (mem_re),
    .mem_rdata(mem_rdata),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_ack = 0, n_err = 0, n_re = 0, n_we = 0, n_rdack = 0;

  logic [11:0] exp_raddr[$];
  logic [15:0] exp_rdata[$];
  logic [11:0] exp_waddr[$];
  logic [15:0] exp_wdata[$];
  logic [15:0] ref_mem [4096];
  logic [15:0] mem [4096];
  bit          loaded;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {15'd0, bus.cw_ack, bus.cw_err, bus.cw_io_oe, bus.cw_io_o,
            mem_re, mem_we, mem_addr, mem_wdata};
  endfunction

  // backing memory: one-cycle read latency
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'h0000;
      mem[12'h000] <= 16'h000e;
      mem[12'h001] <= 16'h0100;
      mem[12'hfff] <= 16'h5a5a;
      loaded <= 1'b1;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cw_ack) n_ack++;
      if (bus.cw_err) n_err++;
      if (mem_re) begin
        n_re++;
        check("re_expected", exp_raddr.size() != 0, 1);
        if (exp_raddr.size() != 0) check("rd_addr", mem_addr, exp_raddr.pop_front());
      end
      if (bus.cw_ack && bus.cw_io_oe) begin
        n_rdack++;
        check("rdata_expected", exp_rdata.size() != 0, 1);
        if (exp_rdata.size() != 0) check("rd_data", bus.cw_io_o, exp_rdata.pop_front());
      end
      if (mem_we) begin
        n_we++;
        check("we_ack", bus.cw_ack, 1);
        check("we_expected", exp_waddr.size() != 0, 1);
        if (exp_waddr.size() != 0) begin
          check("wr_addr", mem_addr, exp_waddr.pop_front());
          check("wr_data", mem_wdata, exp_wdata.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_burst(input logic [15:0] hdr, input logic [15:0] a16, input int n);
    logic [23:0] a;
    logic [15:0] first;
    int start, re0, b;
    a = {hdr[15:8], a16};
    for (int i = 0; i < n; i++) begin
      exp_raddr.push_back(a[11:0]);
      exp_rdata.push_back(ref_mem[a[11:0]]);
      a = a + 24'd1;
    end
    first = ref_mem[a16[11:0]];
    start = n_rdack;
    re0   = n_re;
    bus.cw_req = 1'b1; bus.cw_io_i = hdr;
    step();
    bus.cw_io_i = a16;
    step();
    bus.cw_io_i = 16'h0000; bus.cw_dir = 1'b1;
    @(negedge clk); check("rd_hdr_ack", bus.cw_ack, 1);
    @(negedge clk); check("rd_dir_re", mem_re, 1);
    @(negedge clk); check("rd_first_ack", bus.cw_ack & bus.cw_io_oe, 1);
    if (n > 1) begin
      @(negedge clk);
      check("rd_gap_ack", bus.cw_ack, 0);
      check("rd_hold", bus.cw_io_o, first);
    end
    b = 0;
    while (n_rdack - start < n && b < 64) begin @(posedge clk); b++; end
    #1;
    check("rd_words", n_rdack - start, n);
    bus.cw_req = 1'b0; bus.cw_dir = 1'b0;
    step(); step();
    @(negedge clk);
    check("rd_io_idle", bus.cw_io_o, 0);
    check("rd_re_cnt", n_re - re0, n);
    check("rd_q_empty", exp_rdata.size(), 0);
    step();
  endtask

  task automatic wr_burst(input logic [15:0] hdr, input logic [15:0] a16, input int n,
                          input int stop, input logic [15:0] base);
    logic [23:0] a;
    int we0;
    a = {hdr[15:8], a16};
    for (int k = 0; k < stop; k++) begin
      exp_waddr.push_back(a[11:0]);
      exp_wdata.push_back(base + 16'(k));
      ref_mem[a[11:0]] = base + 16'(k);
      a = a + 24'd1;
    end
    we0 = n_we;
    bus.cw_req = 1'b1; bus.cw_io_i = hdr;
    step();
    bus.cw_io_i = a16;
    step();
    bus.cw_io_i = 16'h0000;
    @(negedge clk); check("wr_hdr_ack", bus.cw_ack, 1);
    for (int k = 0; k < stop; k++) begin
      step();
      bus.cw_io_i = base + 16'(k);
      @(negedge clk); check("wr_ack", bus.cw_ack, 1);
      step();
      bus.cw_io_i = 16'h0000;
      if (k == stop - 1 && stop < n) bus.cw_req = 1'b0;
      @(negedge clk); check("wr_gap_ack", bus.cw_ack, 0);
    end
    step();
    bus.cw_req = 1'b0;
    step(); step(); step();
    check("wr_we_cnt", n_we - we0, stop);
    check("wr_q_empty", exp_waddr.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int start, we0, re0, ack0, err0, b;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0000;
    ref_mem[12'h000] = 16'h000e;
    ref_mem[12'h001] = 16'h0100;
    ref_mem[12'hfff] = 16'h5a5a;
    rst = 1'b1;
    bus.cw_req = 1'b0; bus.cw_dir = 1'b0; bus.cw_io_i = 16'h0000;
    #1 check("rst_outputs", outs(), 0);
    step(); step();
    rst = 1'b0;
    step();

`ifndef CW_RESP_ERR_EN
    rd_burst(16'hff17, 16'he000, 8);
    wr_burst(16'h1027, 16'h0080, 8, 8, 16'ha0a0);
    rd_burst(16'hff11, 16'hffff, 2);
`else
    ack0 = n_ack; err0 = n_err; re0 = n_re; we0 = n_we;
    bus.cw_req = 1'b1; bus.cw_io_i = 16'h0117;
    step(); bus.cw_io_i = 16'h0000;
    step();
    @(negedge clk);
    check("err_pulse", bus.cw_err, 1);
    check("err_no_ack", bus.cw_ack, 0);
    step(); bus.cw_req = 1'b0;
    step(); step();
    check("err_cnt", n_err - err0, 1);
    check("err_acks", n_ack - ack0, 0);
    check("err_strobes", (n_re - re0) + (n_we - we0), 0);
    rd_burst(16'h0017, 16'h0000, 8);
`endif

    // invalid op: no ack and no memory traffic
    ack0 = n_ack; re0 = n_re; we0 = n_we;
    bus.cw_req = 1'b1; bus.cw_io_i = 16'h0007;
    step(); bus.cw_io_i = 16'h0000;
    step();
    @(negedge clk); check("inv_hack", bus.cw_ack, 0);
    step(); bus.cw_req = 1'b0;
    step(); step();
    check("inv_acks", n_ack - ack0, 0);
    check("inv_strobes", (n_re - re0) + (n_we - we0), 0);

    // abort after third write word, then read back
    wr_burst(16'h0027, 16'h0200, 8, 3, 16'h3c00);
    @(negedge clk); check("abort_quiet", bus.cw_ack | mem_we, 0);
    step();
    rd_burst(16'h0013, 16'h0200, 4);

    // reset after second read ack
    for (int i = 0; i < 8; i++) begin
      exp_raddr.push_back(12'(i));
      exp_rdata.push_back(ref_mem[i]);
    end
    start = n_rdack; we0 = n_we;
    bus.cw_req = 1'b1; bus.cw_io_i = 16'h0017;
    step(); bus.cw_io_i = 16'h0000;
    step(); bus.cw_dir = 1'b1;
    b = 0;
    while (n_rdack - start < 2 && b < 64) begin @(posedge clk); b++; end
    #1 rst = 1'b1;
    #1 check("rst_mid_outputs", outs(), 0);
    exp_raddr.delete();
    exp_rdata.delete();
    bus.cw_req = 1'b0; bus.cw_dir = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_acks", n_rdack - start, 2);
    check("rst_mid_we", n_we - we0, 0);
    step();
    rd_burst(16'h0013, 16'h0080, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cw_mem_responder.md
Name: cw_mem_responder

Overview:
- External-memory end of the CW bus: the responder that the core's CW bus initiator talks to in CW boot mode.
- Decodes the header and address words, then handshakes read bursts (drives data with `cw_ack` pulses) or write bursts (captures data).
- Backed by a synchronous single-port memory. Used in companion-FPGA/FPGA builds and as a reusable bench model for CW-mode boot and load/store checks.

Parameters:
- MEM_AW, 12, word-address width of backing memory port; mem_addr = low MEM_AW bits of the 24-bit bus word address.
- ADDR_BASE, 24'h000000, lowest accepted word address (used only with CW_RESP_ERR_EN).
- ADDR_LIMIT, 24'hffffff, highest accepted word address (used only with CW_RESP_ERR_EN).

Ports:
- i_clk  in  1  bus clock (core cw_clk domain)
- i_rst  in  1  asynchronous active-high reset
- cw_req  in  1  request from core
- cw_dir  in  1  bus direction from core; 1 = responder drives cw_io_o
- cw_io_i  in  16  word driven by core (header, address, write data)
- cw_io_o  out  16  read data to core
- cw_io_oe  out  1  output enable for cw_io_o pads; equals cw_dir && read-phase state
- cw_ack  out  1  acknowledge pulse
- cw_err  out  1  error pulse (0 unless CW_RESP_ERR_EN)
- mem_addr  out  MEM_AW  memory word address
- mem_re  out  1  memory read strobe; data valid on mem_rdata next cycle
- mem_rdata  in  16  memory read data
- mem_we  out  1  memory write strobe
- mem_wdata  out  16  memory write data

Behaviour:
- Reset: all outputs 0, state IDLE, burst counter 0, address register 0. Reset mid-burst aborts immediately and issues no further mem_we.
- Header word: [15:8] = addr[23:16]; [5:4] = op (01 read, 10 write, 00/11 ignored); [3] reserved; [2:0] = burst length − 1, so 7 = 8 words. Example: 0xff17 = read, addr high 0xff, 8 words.
- Address word: addr[15:0].
- IDLE: cw_req=1 → latch header from cw_io_i → ADDR.
- ADDR (next cycle): latch cw_io_i as addr[15:0] → HACK.
- HACK: cw_ack=1 for exactly one cycle.
  - Read → RD_DIR.
  - Write → WR_DATA.
  - Invalid op → DONE with no ack. The ack is suppressed in the HACK cycle.
- RD_DIR: wait for cw_dir=1; in the cycle it is seen, mem_re=1 at the current address → RD_ACK.
- RD_ACK: cw_io_o=mem_rdata, cw_ack=1, address+1, count+1.
  - Last word → DONE.
  - Otherwise → RD_GAP.
- RD_GAP: cw_ack=0; mem_re=1 for the next address → RD_ACK. Acks therefore alternate high/low, one word per 2 cycles.
- cw_io_o holds its last value between acks and returns to 0 in IDLE.
- WR_DATA: mem_wdata=cw_io_i, mem_we=1, cw_ack=1, address+1, count+1.
  - Last word → DONE.
  - Otherwise → WR_GAP.
- WR_GAP: cw_ack=0 for one cycle → WR_DATA.
- DONE: wait until cw_req=0 and cw_dir=0 → IDLE. A new request is never accepted in the same cycle as the return to IDLE.
- Address increment is 24-bit and wraps 0xffffff → 0x000000. mem_addr is the truncated address.
- cw_req falling before the burst completes → IDLE next cycle; no further mem_re/mem_we; cw_ack=0.
- cw_dir falling during a read burst → treated as abort, same handling as cw_req falling.
- Latency:
  - Header→ack = 2 cycles.
  - First read data: cw_dir seen → ack 1 cycle later.

Optional Feature:
- Macro CW_RESP_ERR_EN.
- Defined: a burst is rejected if its start address or end address (start + len − 1) lies outside [ADDR_BASE, ADDR_LIMIT].
  - In HACK, cw_err=1 for one cycle instead of cw_ack → DONE.
  - No memory access occurs.
- Not defined: cw_err is tied 0 and no range logic is synthesized.

Test Plan:
- Read burst: header 0xff17, addr 0xe000, mem preloaded with 0x000e, 0x0100, then zeros; cw_dir=1 → one ack 2 cycles after header; then 8 acks on alternate cycles; cw_io_o = 0x000e, 0x0100, 0…; mem_addr low bits track 0xe000..0xe007.
- Write burst: header 0x1027, addr 0x0080, data 0xa0a0, 0xa0a1, … → 8 mem_we pulses at 0x100080..0x100087 with matching mem_wdata; one ack per word.
- Wrap: header 0xff11 (read, 2 words), addr 0xffff → reads at 0xffffff then 0x000000.
- Abort: cw_req drops after the 3rd write ack → exactly 3 mem_we, IDLE next cycle; a new read then succeeds.
- Reset mid-read (i_rst pulsed after the 2nd data ack) → all outputs 0 immediately; next request serviced normally.
- With CW_RESP_ERR_EN, ADDR_LIMIT=24'h00ffff: header 0x0117 → cw_err pulse, no cw_ack, no mem strobes; header 0x0017 addr 0x0000 → normal.
